// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : N-channel push-button conditioner: sync, debounce, edge ticks,
//            long-press tick and press-toggled output per channel.
// Revision : 1.0
// ============================================================================
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] toggle
);

    localparam int C_DB_W   = $clog2(DB_CYCLES);
    localparam int C_LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [C_DB_W-1:0]   C_DB_LAST  = C_DB_W'(DB_CYCLES - 1);
    localparam logic [C_LONG_W-1:0] C_LONG_MAX = C_LONG_W'(LONG_CYCLES);
    localparam logic [C_LONG_W-1:0] C_LONG_PRE = C_LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        logic [C_DB_W-1:0]      r_cnt;
        logic [C_LONG_W-1:0]    r_lcnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_long;
        logic                   r_toggle;
        logic                   w_s;
        logic                   w_fall_now;
        logic                   w_long_adv;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn[i]};
            end
        end

        assign w_s        = r_sync[SYNC_STAGES-1];
        assign w_fall_now = (r_state == ST_WAIT_LOW) && !w_s && (r_cnt == C_DB_LAST);
        // The long counter keeps running through a rejected low glitch but stops on a real fall.
        assign w_long_adv = ((r_state == ST_HIGH) || (r_state == ST_WAIT_LOW)) && !w_fall_now;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state  <= ST_LOW;
                r_cnt    <= '0;
                r_lcnt   <= '0;
                r_level  <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_long   <= 1'b0;
                r_toggle <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_long <= 1'b0;
                case (r_state)
                    ST_LOW: begin
                        if (w_s) begin
                            r_state <= ST_WAIT_HIGH;
                            r_cnt   <= '0;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_LOW;
                        end else if (r_cnt == C_DB_LAST) begin
                            r_state  <= ST_HIGH;
                            r_level  <= 1'b1;
                            r_rise   <= 1'b1;
                            r_toggle <= ~r_toggle;
                            r_lcnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!w_s) begin
                            r_state <= ST_WAIT_LOW;
                            r_cnt   <= '0;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (w_s) begin
                            r_state <= ST_HIGH;
                        end else if (r_cnt == C_DB_LAST) begin
                            r_state <= ST_LOW;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_LOW;
                endcase

                // Saturating at the limit yields exactly one long_press per press.
                if (w_long_adv && (r_lcnt != C_LONG_MAX)) begin
                    r_lcnt <= r_lcnt + 1'b1;
                    r_long <= (r_lcnt == C_LONG_PRE);
                end
            end
        end

        assign level[i]      = r_level;
        assign rise[i]       = r_rise;
        assign fall[i]       = r_fall;
        assign long_press[i] = r_long;
        assign toggle[i]     = r_toggle;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Directed self-checking bench for debounce_multi.
// Revision : 1.0
// ============================================================================
module tb_debounce_multi;

    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int LONG_CYCLES = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] level, rise, fall, long_press, toggle;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  el, er, ef, elp, et;
    logic [19:0] got, exp;

    debounce_multi #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .toggle     (toggle)
    );

    always #5 clk = ~clk;

    // Vectors are packed {level, rise, fall, long_press, toggle}, one nibble each.
    task automatic test_reset();
        reset = 1'b1;
        btn   = 4'hF;
        #1;
        got = {level, rise, fall, long_press, toggle};
        n_vec++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL reset_assert got=%h exp=%h", got, 20'h0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            el  = (e >= 7) ? 4'hF : 4'h0;
            er  = (e == 7) ? 4'hF : 4'h0;
            ef  = 4'h0;
            elp = 4'h0;
            et  = (e >= 7) ? 4'hF : 4'h0;
            exp = {el, er, ef, elp, et};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_release e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        reset = 1'b1;
        btn   = 4'h0;
        #1;
        got = {level, rise, fall, long_press, toggle};
        n_vec++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL reset_while_high got=%h exp=%h", got, 20'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int e = 1; e <= 20; e++) begin
            btn[0] = (e <= 5);
            @(negedge clk);
            el  = {3'b000, (e >= 7 && e < 12)};
            er  = {3'b000, (e == 7)};
            ef  = {3'b000, (e == 12)};
            elp = 4'h0;
            et  = {3'b000, (e >= 7)};
            exp = {el, er, ef, elp, et};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_press e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        for (int e = 1; e <= 30; e++) begin
            btn[1] = ((e >= 1 && e <= 4) || (e >= 6 && e <= 9));
            @(negedge clk);
            exp = {4'h0, 4'h0, 4'h0, 4'h0, 4'b0001};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bounce e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_long_press();
        for (int e = 1; e <= 55; e++) begin
            btn[2] = (e <= 40) && !(e == 15 || e == 16);
            @(negedge clk);
            el  = {1'b0, (e >= 7 && e < 47), 2'b00};
            er  = {1'b0, (e == 7), 2'b00};
            ef  = {1'b0, (e == 47), 2'b00};
            elp = {1'b0, (e == 23), 2'b00};
            et  = {1'b0, (e >= 7), 1'b0, 1'b1};
            exp = {el, er, ef, elp, et};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL long_press e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int e = 1; e <= 40; e++) begin
            btn[3] = (e <= 5) || (e >= 21 && e <= 25);
            @(negedge clk);
            el  = {((e >= 7 && e < 12) || (e >= 27 && e < 32)), 3'b000};
            er  = {(e == 7 || e == 27), 3'b000};
            ef  = {(e == 12 || e == 32), 3'b000};
            elp = 4'h0;
            et  = {(e >= 7 && e < 27), 3'b101};
            exp = {el, er, ef, elp, et};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL back_to_back e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        for (int e = 1; e <= 3; e++) begin
            btn[0] = 1'b1;
            @(negedge clk);
            exp = {4'h0, 4'h0, 4'h0, 4'h0, 4'b0101};
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL mid_pre e=%0d got=%h exp=%h", e, got, exp);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        got = {level, rise, fall, long_press, toggle};
        n_vec++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL mid_reset_assert got=%h exp=%h", got, 20'h0);
        end
        @(negedge clk);
        reset  = 1'b0;
        btn[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            got = {level, rise, fall, long_press, toggle};
            n_vec++;
            if (got !== 20'h0) begin
                n_err++;
                $display("FAIL mid_release e=%0d got=%h exp=%h", e, got, 20'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button conditioner; successor to the single-button debouncer. Each of N_CH raw, asynchronous button inputs passes through a synchroniser and a per-channel debounce state machine. Per channel, the block produces a clean level, one-cycle rise and fall ticks, a one-shot long-press tick and a press-toggled output. It sits between the board pins and the application logic (LED/control FSMs) in the top level.

## Interface
- N_CH, 4: number of independent button channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DB_CYCLES, 2_000_000: debounce time in clocks (20 ms at 100 MHz); legal range ≥2
- LONG_CYCLES, 100_000_000: long-press time in clocks after rise (1 s at 100 MHz); legal range ≥2
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- btn  in  N_CH  raw button inputs, asynchronous, active-high
- level  out  N_CH  debounced level
- rise  out  N_CH  one-cycle pulse when level goes 0→1
- fall  out  N_CH  one-cycle pulse when level goes 1→0
- long_press  out  N_CH  one-cycle pulse per press held LONG_CYCLES
- toggle  out  N_CH  flips on every rise

## Operation
- Channels are fully independent. Logic is replicated per channel and no state is shared.
- Synchroniser: btn[i] feeds SYNC_STAGES flops. s[i] is the last stage. The FSM sees only s[i].
- Debounce counter width is $clog2(DB_CYCLES). Long counter width is $clog2(LONG_CYCLES+1).
- FSM states and transitions:
  - LOW, s=1: go to WAIT_HIGH and clear cnt.
  - WAIT_HIGH, s=0: go to LOW. This is a bounce; no tick.
  - WAIT_HIGH, s=1 and cnt<DB_CYCLES-1: cnt++.
  - WAIT_HIGH, s=1 and cnt==DB_CYCLES-1: go to HIGH and pulse rise. toggle flips, and the long counter clears and is armed.
  - HIGH, s=0: go to WAIT_LOW and clear cnt.
  - WAIT_LOW, s=1: go back to HIGH with no tick. The long counter is not cleared.
  - WAIT_LOW, s=0 and cnt==DB_CYCLES-1: go to LOW and pulse fall. The long counter disarms.
- level = 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH. level is registered.
- Long counter:
  - It increments every cycle while armed (HIGH or WAIT_LOW).
  - On reaching LONG_CYCLES it pulses long_press once and saturates. No further pulse occurs until the next rise.
  - A fall before that point suppresses the pulse.
- All outputs are registered; no combinational path from btn to any output.

## Timing
- Reset: all synchroniser flops 0, FSM LOW, counters 0; level, rise, fall, long_press and toggle are all 0 immediately on reset assertion (asynchronous).
- Reset mid-operation: every channel returns to LOW at once. No tick is emitted on assert or release.
- Button held across reset release: this is treated as a fresh press with full latency.
- Rise latency: count the first clk edge sampling btn[i]=1 as edge 1. level[i] and rise[i] go high after edge SYNC_STAGES+DB_CYCLES+1, provided btn stays high.
- Fall latency is symmetric: after edge SYNC_STAGES+DB_CYCLES+1, counting from the first edge sampling 0.
- Pulse rejection: a btn high (or low) run of ≤DB_CYCLES edges never changes level. A run of ≥DB_CYCLES+1 edges does.
- Tick widths:
  - rise, fall and long_press are exactly one cycle wide.
  - long_press is asserted LONG_CYCLES cycles after the rise cycle.
- Coincidences:
  - rise and fall can never coincide on one channel; ticks on different channels may coincide in the same cycle.
  - long_press and fall cannot coincide, since a fall disarms the counter first.

## Test plan
Bench parameters: N_CH=4, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=16, 10 ns clock.

- Reset: reset=1 with btn=4'hF → all outputs 0. Release with btn=4'hF held → rise=4'hF after edge 7, toggle=4'hF.
- Clean press: btn[0]=1 for 5 edges, then 0.
  - level[0] goes 1 after edge 7, with rise[0] high for one cycle.
  - level[0] goes 0 after the 7th edge sampling 0, with fall[0] high for one cycle.
  - toggle[0]=1 throughout, and long_press[0] never fires.
- Bounce rejection: btn[1] pattern 4×1, 1×0, 4×1, 1×0, then 0 → level[1], rise[1] and fall[1] stay 0 throughout.
- Long press: btn[2]=1 for 40 edges.
  - rise[2] fires at cycle t.
  - long_press[2] fires exactly once, at t+16.
  - A 2-edge low glitch at t+8 does not clear the long counter and does not disturb level[2].
- Short press then second press: two clean presses on btn[3] → toggle[3] goes 1 then 0; long_press[3] never fires.
- Reset mid-debounce: assert reset while btn[0] has been high for 3 edges → outputs 0 immediately. Release with btn[0]=0 → no rise[0] ever.
